// File: rtl/global_config_pkg.sv
// Shared configuration package for the pipeline handshake blocks.
// Holds the valid/ready handshake bundle, the skid buffer state encoding
// and a small helper that decides whether a beat moves on a given edge.
package global_config_pkg;

    // One side of a valid/ready link as seen at a single clock edge.
    typedef struct packed {
        logic valid;
        logic ready;
    } handshake_t;

    // Occupancy of a two-entry skid buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    // Width of the optional performance counters.
    localparam int unsigned HS_PERF_CNT_W = 32;

    // A beat transfers on an edge only when both valid and ready are high.
    function automatic logic hs_xfer(input handshake_t hs);
        return hs.valid & hs.ready;
    endfunction

endpackage

// File: rtl/hs_sat_counter.sv
// Saturating up-counter used by the skid buffer performance monitors.
// Counts edges on which inc_i is high and sticks at the all-ones value
// instead of wrapping, so a long-running stall never reads back as small.
module hs_sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             at_max;

    assign at_max = &cnt_q;

    // Next count: step by one when asked, but never past the top value.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !at_max) begin
            cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Count register, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hs_skid_buffer.sv
// Two-entry skid buffer for the valid/ready pipeline handshake.
// Every output is a flop, so ready timing from downstream never reaches
// upstream in the same cycle. A main register feeds the output and a skid
// register catches the one beat that arrives while downstream stalls.
// Optional feature: define TRIATHLON_HS_PERF_EN to add the stall_cnt_o and
// full_cnt_o saturating performance counters.
module hs_skid_buffer
    import global_config_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o
`ifdef TRIATHLON_HS_PERF_EN
    ,
    output logic [HS_PERF_CNT_W-1:0] stall_cnt_o,
    output logic [HS_PERF_CNT_W-1:0] full_cnt_o
`endif
);

    skid_state_e       state_q;
    skid_state_e       state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;
    logic              out_valid_q;
    logic              out_valid_d;
    logic              in_ready_q;
    logic              in_ready_d;

    handshake_t        in_hs;
    handshake_t        out_hs;
    logic              in_xfer;
    logic              out_xfer;

    // Handshakes are judged against the registered ready/valid, never
    // against anything derived combinationally from the other side.
    assign in_hs.valid  = in_valid_i;
    assign in_hs.ready  = in_ready_q;
    assign out_hs.valid = out_valid_q;
    assign out_hs.ready = out_ready_i;
    assign in_xfer      = hs_xfer(in_hs);
    assign out_xfer     = hs_xfer(out_hs);

    // Occupancy FSM and datapath steering; flush overrides every transfer.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d = BUSY;
                        main_d  = in_data_i;
                    end
                end
                BUSY: begin
                    if (in_xfer && !out_xfer) begin
                        state_d = FULL;
                        skid_d  = in_data_i;
                    end else if (in_xfer && out_xfer) begin
                        main_d  = in_data_i;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        state_d = BUSY;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != FULL);
    end

    // State, payload and handshake flops; ready stays low throughout reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = main_q;

`ifdef TRIATHLON_HS_PERF_EN
    logic stall_inc;
    logic full_inc;

    // A stall is a cycle where a beat is offered downstream but refused.
    assign stall_inc = out_valid_q & ~out_ready_i;
    assign full_inc  = (state_q == FULL);

    hs_sat_counter #(
        .WIDTH (HS_PERF_CNT_W)
    ) u_stall_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (stall_inc),
        .cnt_o  (stall_cnt_o)
    );

    hs_sat_counter #(
        .WIDTH (HS_PERF_CNT_W)
    ) u_full_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (full_inc),
        .cnt_o  (full_cnt_o)
    );
`endif

endmodule

// File: tb/tb_hs_skid_buffer.sv
// Self-checking bench for hs_skid_buffer and its saturating counter.
// Directed scenarios plus a randomised valid/ready run against a queue model.
module tb_hs_skid_buffer;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
`ifdef TRIATHLON_HS_PERF_EN
    logic [31:0]   stall_cnt;
    logic [31:0]   full_cnt;
`endif

    logic          sat_inc = 1'b0;
    logic [3:0]    sat_cnt;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hs_skid_buffer #(.DATA_W(W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data)
`ifdef TRIATHLON_HS_PERF_EN
        ,
        .stall_cnt_o (stall_cnt),
        .full_cnt_o  (full_cnt)
`endif
    );

    hs_sat_counter #(.WIDTH(4)) u_sat (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .inc_i  (sat_inc),
        .cnt_o  (sat_cnt)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_in_ready got %0b want 0", in_ready); end
        n_cmp++; if (out_data !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_out_data got %h want 0", out_data); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL release_in_ready got %0b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL release_out_valid got %0b want 0", out_valid); end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = i;
            tick();
            n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL stream_in_ready[%0d] got %0b want 1", i, in_ready); end
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stream_out_valid[%0d] got %0b want 1", i, out_valid); end
            n_cmp++; if (out_data !== i) begin n_fail++; $display("[TB] FAIL stream_data[%0d] got %h want %h", i, out_data, i); end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stream_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        tick();
        n_cmp++; if (out_data !== 32'hA) begin n_fail++; $display("[TB] FAIL bp_first got %h want a", out_data); end
        in_data = 32'hB;
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_full_ready got %0b want 0", in_ready); end
        in_data = 32'hC;
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_hold_ready got %0b want 0", in_ready); end
        n_cmp++; if (out_data !== 32'hA) begin n_fail++; $display("[TB] FAIL bp_hold_data got %h want a", out_data); end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_data !== 32'hB) begin n_fail++; $display("[TB] FAIL bp_second got %h want b", out_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_reopen got %0b want 1", in_ready); end
        tick();
        n_cmp++; if (out_data !== 32'hC) begin n_fail++; $display("[TB] FAIL bp_third got %h want c", out_data); end
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_third_valid got %0b want 1", out_valid); end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_no_dup got %0b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        tick();
        in_data = 32'h22;
        tick();
        in_data   = 32'h33;
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_valid got %0b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_ready got %0b want 1", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_no_beat got %0b want 0", out_valid); end
        in_valid = 1'b1;
        in_data  = 32'h44;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_empty got %0b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h55;
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL async_rst_valid got %0b want 0", out_valid); end
        n_cmp++; if (out_data !== 32'h0) begin n_fail++; $display("[TB] FAIL async_rst_data got %h want 0", out_data); end
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_mid_ready got %0b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_valid got %0b want 0", out_valid); end
    endtask

    task automatic test_random();
        logic [W-1:0] sb[$];
        logic hold;
        logic in_x;
        logic out_x;
        logic rdy0;
        logic vld0;
        hold = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            n_cmp++; if (in_ready !== (sb.size() != 2)) begin n_fail++; $display("[TB] FAIL rnd_ready[%0d] got %0b want %0b", c, in_ready, sb.size() != 2); end
            n_cmp++; if (out_valid !== (sb.size() != 0)) begin n_fail++; $display("[TB] FAIL rnd_valid[%0d] got %0b want %0b", c, out_valid, sb.size() != 0); end
            if (!hold) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = $urandom;
            end
            out_ready = ($urandom_range(0, 99) >= 30);
            flush     = ($urandom_range(0, 199) == 0);
            if ((c % 16) == 0) begin
                rdy0 = in_ready;
                vld0 = out_valid;
                out_ready = ~out_ready;
                in_valid  = ~in_valid;
                #1;
                n_cmp++; if (in_ready !== rdy0) begin n_fail++; $display("[TB] FAIL comb_ready[%0d] got %0b want %0b", c, in_ready, rdy0); end
                n_cmp++; if (out_valid !== vld0) begin n_fail++; $display("[TB] FAIL comb_valid[%0d] got %0b want %0b", c, out_valid, vld0); end
                out_ready = ~out_ready;
                in_valid  = ~in_valid;
                #1;
            end
            in_x  = in_valid && (sb.size() != 2);
            out_x = out_ready && (sb.size() != 0);
            if (flush) begin
                sb.delete();
                hold = 1'b0;
            end else begin
                if (out_x) begin
                    n_cmp++; if (out_data !== sb[0]) begin n_fail++; $display("[TB] FAIL rnd_data[%0d] got %h want %h", c, out_data, sb[0]); end
                    void'(sb.pop_front());
                end
                if (in_x) sb.push_back(in_data);
                hold = in_valid && !in_x;
            end
            tick();
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_sat_counter();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (sat_cnt !== 4'd0) begin n_fail++; $display("[TB] FAIL sat_reset got %0d want 0", sat_cnt); end
        sat_inc = 1'b1;
        repeat (3) tick();
        n_cmp++; if (sat_cnt !== 4'd3) begin n_fail++; $display("[TB] FAIL sat_count got %0d want 3", sat_cnt); end
        repeat (12) tick();
        n_cmp++; if (sat_cnt !== 4'd15) begin n_fail++; $display("[TB] FAIL sat_top got %0d want 15", sat_cnt); end
        repeat (5) tick();
        n_cmp++; if (sat_cnt !== 4'd15) begin n_fail++; $display("[TB] FAIL sat_stick got %0d want 15", sat_cnt); end
        sat_inc = 1'b0;
    endtask

`ifdef TRIATHLON_HS_PERF_EN
    task automatic test_perf_counters();
        logic [31:0] s0;
        logic [31:0] f0;
        s0 = stall_cnt;
        f0 = full_cnt;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1;
        in_data  = 32'hB;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        n_cmp++; if (stall_cnt - s0 !== 32'd5) begin n_fail++; $display("[TB] FAIL perf_stall got %0d want 5", stall_cnt - s0); end
        n_cmp++; if (full_cnt - f0 !== 32'd3) begin n_fail++; $display("[TB] FAIL perf_full got %0d want 3", full_cnt - f0); end
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (stall_cnt - s0 !== 32'd5) begin n_fail++; $display("[TB] FAIL perf_stall_flush got %0d want 5", stall_cnt - s0); end
        n_cmp++; if (full_cnt - f0 !== 32'd4) begin n_fail++; $display("[TB] FAIL perf_full_flush got %0d want 4", full_cnt - f0); end
    endtask
`endif

    initial begin
        $display("[TB] starting hs_skid_buffer bench");
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
`ifdef TRIATHLON_HS_PERF_EN
        test_perf_counters();
`endif
        test_reset_mid();
        test_random();
        test_sat_counter();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
